// File: rtl/if_fetch_stage_pkg.sv
// Shared defines for the instruction-fetch stage: widths, fetch FSM encoding and the NOP word.
// Imported by if_fetch_stage and if_fetch_buffer.
package if_fetch_stage_pkg;

    localparam int ADDRESS_LEN     = 32;
    localparam int INSTRUCTION_LEN = 32;

    typedef logic [ADDRESS_LEN-1:0]     addr_t;
    typedef logic [INSTRUCTION_LEN-1:0] instr_t;

    localparam instr_t NOP     = 32'h0000_0000;
    localparam addr_t  PC_STEP = 32'd4;

    // FETCH: request outstanding; HOLD: word parked in buffer; KILL: stale request draining
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    // Sequential next address, modulo 2^32
    function automatic addr_t pc_inc(input addr_t a);
        return a + PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry holding register for an instruction word and its fetch address.
// Clear wins over load; only the full flag is reset, the payload is qualified by it.
module if_fetch_buffer
    import if_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_i,
    input  logic   clear_i,
    input  instr_t instr_i,
    input  addr_t  addr_i,
    output logic   full_o,
    output instr_t instr_o,
    output addr_t  addr_o
);

    logic   full_q, full_d;
    instr_t instr_q;
    addr_t  addr_q;

    always_comb begin
        full_d = full_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_i && !clear_i) begin
            instr_q <= instr_i;
            addr_q  <= addr_i;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign addr_o  = addr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: request/ack memory handshake, freeze buffering and branch redirect.
// Optional macro IF_PERF_COUNTERS_EN adds fetch_count / stall_count outputs.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [ADDRESS_LEN-1:0]     branch_address,
    output logic                       imem_req,
    output logic [ADDRESS_LEN-1:0]     imem_addr,
    input  logic                       imem_ack,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    output logic [ADDRESS_LEN-1:0]     PC,
    output logic [INSTRUCTION_LEN-1:0] Instruction,
    output logic                       valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]                fetch_count,
    output logic [31:0]                stall_count
`endif
);

    fetch_state_e state_q, state_d;
    addr_t        fetch_pc_q, fetch_pc_d;
    addr_t        stale_addr_q, stale_addr_d;
    addr_t        pc_q, pc_d;
    instr_t       instr_q, instr_d;
    logic         valid_q, valid_d;

    logic         buf_load, buf_clear, buf_full;
    instr_t       buf_instr;
    addr_t        buf_addr;

    logic         deliver;
    instr_t       deliver_instr;
    addr_t        deliver_addr;

    if_fetch_buffer u_buffer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (imem_rdata),
        .addr_i  (fetch_pc_q),
        .full_o  (buf_full),
        .instr_o (buf_instr),
        .addr_o  (buf_addr)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        stale_addr_d  = stale_addr_q;
        buf_load      = 1'b0;
        buf_clear     = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_addr  = fetch_pc_q;

        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    fetch_pc_d = branch_address;
                    // The in-flight request cannot be withdrawn; drain it under its old address.
                    if (!imem_ack) begin
                        stale_addr_d = fetch_pc_q;
                        state_d      = KILL;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = pc_inc(fetch_pc_q);
                    if (freeze) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        deliver = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    buf_clear  = 1'b1;
                    fetch_pc_d = branch_address;
                    state_d    = FETCH;
                end else if (!freeze && buf_full) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_instr;
                    deliver_addr  = buf_addr;
                    buf_clear     = 1'b1;
                    state_d       = FETCH;
                end
            end
            KILL: begin
                if (branch_taken) begin
                    fetch_pc_d = branch_address;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Output register: branch flushes even under freeze, freeze otherwise holds everything.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (branch_taken) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (deliver) begin
            valid_d = 1'b1;
            instr_d = deliver_instr;
            pc_d    = pc_inc(deliver_addr);
        end else if (!freeze) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= '0;
            pc_q       <= '0;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        stale_addr_q <= stale_addr_d;
    end

    assign imem_req    = !rst && (state_q != HOLD);
    assign imem_addr   = (state_q == KILL) ? stale_addr_q : fetch_pc_q;
    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign valid       = valid_q;

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'd0, (deliver && !branch_taken)};
        stall_count_d = stall_count_q + {31'd0, freeze};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule
